h_alpha_stream_driver: RTL and testbench
========================================

# h_alpha_stream_driver

Parametrised stimulus source for the fixed-point `top_fix_case2` core. It replaces the fixed-size, one-shot, start-driven wrapper with a generator that has the following properties:
- J, I, A and the alpha data width are parameters.
- The H-row and alpha_u-column AXI-Stream outputs honour backpressure.
- Runs of several frames are supported.
- A run-time mode selects clean flow or one of two injected bad-flow patterns.

The block sits between the testbench or top-level control and the core's two input streams.

## Interface
Parameters:
- `J`, 14: number of H rows and alpha elements per column.
- `I`, 7: H row width in bits.
- `A`, 2: number of alpha_u columns per frame.
- `DATA_W`, 16: alpha element width.
- `FRM_W`, 8: width of the frame-count input.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle request. Ignored while `busy`.
- `mode`, in, 2: sampled at accepted `start`. 0 = clean, 1 = bubble, 2 = early-tlast, 3 = clean.
- `frames`, in, FRM_W: sampled at accepted `start`. 0 is treated as 1.
- `alpha_base`, in, DATA_W: sampled at accepted `start`.
- `H_row`, out, I: H stream data.
- `H_row_tvalid`, out, 1: H stream valid.
- `H_row_tready`, in, 1: H stream ready.
- `H_row_tlast`, out, 1: H stream last.
- `alpha_u_col`, out, DATA_W: alpha stream data.
- `alpha_u_col_tvalid`, out, 1: alpha stream valid.
- `alpha_u_col_tready`, in, 1: alpha stream ready.
- `alpha_u_col_tlast`, out, 1: alpha stream last.
- `busy`, out, 1: high from the cycle after accepted `start` until `done`.
- `done`, out, 1: one-cycle pulse after the last alpha beat of the last frame.
- `frame_idx`, out, FRM_W: index of the frame currently being sent.

## Operation
- States: IDLE, H_SEND, A_SEND, NEXT, DONE.
- IDLE → H_SEND on `start` while not `busy`. Latch `mode`, `frames` and `alpha_base`. Clear `frame_idx`.
- H_SEND sends beat j = 0..J-1.
  - `H_row` has bit (j mod I) and bit ((j+1) mod I) set; all other bits are 0.
  - `tlast` is asserted on j = J-1.
  - In mode 2, `tlast` is asserted on j = J-2 instead, and the phase ends there after J-1 beats.
- A_SEND sends column a = 0..A-1, element j = 0..J-1, column-major.
  - `alpha_u_col` = `alpha_base` + a·J + j, truncated to DATA_W (wraps modulo 2^DATA_W).
  - `tlast` is asserted on j = J-1 of every column.
- NEXT: if `frame_idx` + 1 < effective frames, increment `frame_idx` and go to H_SEND. Otherwise go to DONE.
- DONE: assert `done` for one cycle, deassert `busy`, go to IDLE.
- A beat transfers when tvalid and tready are both high. While tvalid is high and tready is low, data and tlast hold stable.
- Mode 1 (bubble): after every transferred beat on either stream, tvalid stays low for exactly one cycle, then the next beat is presented.
- Only one stream is ever valid at a time. The H and alpha streams never overlap.

## Timing
- Reset values:
  - All tvalid, tlast, `busy` and `done` are 0.
  - `H_row`, `alpha_u_col` and `frame_idx` are 0.
  - The state is IDLE.
- Reset mid-run: all outputs return to their reset values on the next edge. No partial beats are completed.
- Latency:
  - `H_row_tvalid` rises 1 cycle after accepted `start`.
  - The first alpha beat is presented the cycle after the H `tlast` transfer.
  - NEXT costs 1 cycle, and DONE costs 1 cycle.
- Clean mode with constant tready = 1: a frame takes J + A·J cycles with no gaps between beats inside a phase.
- `start` in the same cycle as `done`: the `start` is ignored, because `busy` is still 1.
- tready is allowed high while tvalid is low. This has no effect.

## Structure
- A shared package holds:
  - mode localparams (MODE_CLEAN, MODE_BUBBLE, MODE_EARLY_LAST);
  - the state encoding;
  - `J_WIDTH` = $clog2(J)+1, `I_WIDTH` and `A_WIDTH` width helpers.
- Sub-module `axis_src_slot` is instantiated twice, once per stream. It holds one output register stage plus the valid/hold/bubble logic. It has a `load` input and accepts a `fire` indication.
- The top level holds the FSM, the j/a/frame counters and the data generators.

## Test plan
- Reset, then `start` with mode 0, frames 1, `alpha_base` 0x0100, tready = 1 → 14 H beats.
  - Beat 0 = 7'b0000011, beat 6 = 7'b1000001, `tlast` on beat 13.
  - Then 28 alpha beats, 0x0100..0x011B, with `tlast` on 0x010D and 0x011B.
  - `done` pulses once, 44 cycles after `start`.
- Random tready at 50% → beat sequence identical to the previous case. Data and tlast are stable on every cycle where valid = 1 and ready = 0.
- Mode 1 → exactly one tvalid-low cycle between consecutive beats. Total run is 2·(14+28)−2 data/gap cycles plus overhead.
- Mode 2 → H `tlast` on beat 12, only 13 H beats. The alpha phase is unchanged.
- Frames 3 with `alpha_base` 0xFFF0 → `frame_idx` steps 0, 1, 2. Alpha wraps from 0xFFFF to 0x0000 at beat 16 of each frame. A single `done` pulse at the end.
- `rst` asserted during A_SEND → outputs return to reset values the next cycle. A fresh `start` then runs a clean full frame.

Source files
------------

// File: rtl/h_alpha_stream_driver_pkg.sv
// Shared definitions for the H-row / alpha_u-column stimulus driver:
// run modes, FSM state encoding and counter width helpers.
package h_alpha_stream_driver_pkg;

    // Run modes sampled at an accepted start. Code 3 behaves like clean.
    localparam logic [1:0] MODE_CLEAN      = 2'd0;
    localparam logic [1:0] MODE_BUBBLE     = 2'd1;
    localparam logic [1:0] MODE_EARLY_LAST = 2'd2;

    // Frame sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_H_SEND = 3'd1,
        ST_A_SEND = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Counter width able to hold every value 0..n.
    function automatic int j_width(input int j);
        return $clog2(j) + 1;
    endfunction

    // Width of a bit index into an H row (one spare bit keeps I = 1 legal).
    function automatic int i_width(input int i);
        return $clog2(i) + 1;
    endfunction

    // Width of the alpha column counter.
    function automatic int a_width(input int a);
        return $clog2(a) + 1;
    endfunction

endpackage

// File: rtl/h_alpha_stream_driver_if.sv
// The two AXI-Stream style outputs of the driver: H rows and alpha_u columns.
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high; while tvalid is high and tready is low, data and tlast hold
// stable and tvalid stays high. tready may be high while tvalid is low.
interface h_alpha_stream_driver_if #(
    parameter int I      = 7,
    parameter int DATA_W = 16
);
    logic [I-1:0]      H_row;
    logic              H_row_tvalid;
    logic              H_row_tready;
    logic              H_row_tlast;

    logic [DATA_W-1:0] alpha_u_col;
    logic              alpha_u_col_tvalid;
    logic              alpha_u_col_tready;
    logic              alpha_u_col_tlast;

    // The driver side produces data, valid and last.
    modport master (
        output H_row, H_row_tvalid, H_row_tlast,
        input  H_row_tready,
        output alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
        input  alpha_u_col_tready
    );

    // The consuming core side only drives ready.
    modport slave (
        input  H_row, H_row_tvalid, H_row_tlast,
        output H_row_tready,
        input  alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast,
        output alpha_u_col_tready
    );

endinterface

// File: rtl/h_alpha_stream_driver_axis_src_slot.sv
// One output register stage of a stream source. The owner presents a new
// beat with load_i whenever free_o is high; the slot keeps valid/data/last
// stable until fire_i (valid & ready) and, in bubble mode, forces a single
// idle cycle after every transferred beat.
module axis_src_slot
    import h_alpha_stream_driver_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         fire_i,
    input  logic         bubble_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         last_o,
    output logic         free_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         last_q,  last_d;

    // Next beat: load wins, a transfer empties the stage, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
        end else if (fire_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // Back-to-back reload on a transfer only in non-bubble mode; in bubble
    // mode the stage must be seen empty for one cycle before it reloads.
    assign free_o  = !valid_q || (fire_i && !bubble_i);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/h_alpha_stream_driver.sv
// Parametrised stimulus source for the fixed-point core: per frame it sends
// J one-hot-pair H rows, then A alpha_u columns of J elements each, for a
// run of several frames, with clean, bubble or early-tlast flow.
module h_alpha_stream_driver
    import h_alpha_stream_driver_pkg::*;
#(
    parameter int J      = 14,
    parameter int I      = 7,
    parameter int A      = 2,
    parameter int DATA_W = 16,
    parameter int FRM_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic [FRM_W-1:0]           frames,
    input  logic [DATA_W-1:0]          alpha_base,
    h_alpha_stream_driver_if.master    s_if,
    output logic                       busy,
    output logic                       done,
    output logic [FRM_W-1:0]           frame_idx,
    output state_e                     dbg_state_o
);

    localparam int J_WIDTH = j_width(J);
    localparam int I_WIDTH = i_width(I);
    localparam int A_WIDTH = a_width(A);

    localparam logic [J_WIDTH-1:0] J_LAST       = J_WIDTH'(J - 1);
    localparam logic [J_WIDTH-1:0] J_LAST_EARLY = J_WIDTH'(J - 2);
    localparam logic [A_WIDTH-1:0] A_LAST       = A_WIDTH'(A - 1);
    localparam logic [I_WIDTH-1:0] I_LAST       = I_WIDTH'(I - 1);

    state_e               state_q;
    logic [1:0]           mode_q;
    logic [FRM_W-1:0]     frames_q;
    logic [DATA_W-1:0]    base_q;
    logic [FRM_W-1:0]     frame_q;
    logic [J_WIDTH-1:0]   j_q;
    logic [A_WIDTH-1:0]   a_q;
    logic                 all_loaded_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 start_acc;
    logic                 early;
    logic                 bubble;
    logic                 more_frames;

    logic                 h_valid, h_last, h_free, h_fire, h_fin, h_load, h_last_d;
    logic [J_WIDTH-1:0]   h_idx;
    logic [I_WIDTH-1:0]   h_bit0, h_bit1;
    logic [I-1:0]         h_row_d;

    logic                 a_valid, a_last, a_free, a_fire, a_fin, a_load, a_last_d, a_final;
    logic [J_WIDTH-1:0]   a_j_idx;
    logic [A_WIDTH-1:0]   a_a_idx;
    logic [DATA_W-1:0]    alpha_d;

    // Control decode: start acceptance, mode flags, frame continuation and
    // the load/finish conditions of both stream slots.
    always_comb begin
        start_acc   = (state_q == ST_IDLE) && start && !busy_q;
        // The very first H beat is loaded in the start cycle, before mode_q
        // holds the new mode, so the live input is used there.
        early       = ((start_acc ? mode : mode_q) == MODE_EARLY_LAST);
        bubble      = (mode_q == MODE_BUBBLE);
        more_frames = ({1'b0, frame_q} + (FRM_W + 1)'(1)) < {1'b0, frames_q};

        h_fire   = h_valid && s_if.H_row_tready;
        a_fire   = a_valid && s_if.alpha_u_col_tready;

        // H phase ends on the transfer of its tlast beat (J-1 or J-2).
        h_fin    = (state_q == ST_H_SEND) && h_fire && h_last;
        // Alpha phase ends on the transfer of the final element loaded.
        a_fin    = (state_q == ST_A_SEND) && a_fire && all_loaded_q;

        // H beat 0 is loaded on the start or NEXT edge so it is valid in the
        // first cycle of the phase; later beats follow whenever the slot is free.
        h_idx    = (state_q == ST_H_SEND) ? j_q : '0;
        h_last_d = (h_idx == (early ? J_LAST_EARLY : J_LAST));
        h_load   = start_acc
                || ((state_q == ST_NEXT) && more_frames)
                || ((state_q == ST_H_SEND) && !all_loaded_q && h_free);

        // Alpha element 0 is loaded on the H tlast transfer edge, so the
        // switch between streams costs no cycle even in bubble mode.
        a_j_idx  = (state_q == ST_A_SEND) ? j_q : '0;
        a_a_idx  = (state_q == ST_A_SEND) ? a_q : '0;
        a_last_d = (a_j_idx == J_LAST);
        a_final  = a_last_d && (a_a_idx == A_LAST);
        a_load   = h_fin || ((state_q == ST_A_SEND) && !all_loaded_q && a_free);
    end

    // Data generators: H row with bits (j mod I) and ((j+1) mod I) set, and
    // alpha = base + a*J + j wrapping modulo 2^DATA_W.
    always_comb begin
        h_bit0 = I_WIDTH'(int'(h_idx) % I);
        h_bit1 = (h_bit0 == I_LAST) ? '0 : h_bit0 + 1'b1;
        for (int b = 0; b < I; b++) begin
            h_row_d[b] = (I_WIDTH'(b) == h_bit0) || (I_WIDTH'(b) == h_bit1);
        end
        alpha_d = base_q + DATA_W'(int'(a_a_idx) * J + int'(a_j_idx));
    end

    // Frame sequencing FSM with the beat/column/frame counters and the
    // registered busy/done outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_CLEAN;
            frames_q     <= '0;
            base_q       <= '0;
            frame_q      <= '0;
            j_q          <= '0;
            a_q          <= '0;
            all_loaded_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_acc) begin
                        state_q  <= ST_H_SEND;
                        mode_q   <= mode;
                        frames_q <= (frames == '0) ? FRM_W'(1) : frames;
                        base_q   <= alpha_base;
                        frame_q  <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_H_SEND: begin
                    if (h_fin) state_q <= ST_A_SEND;
                end
                ST_A_SEND: begin
                    if (a_fin) state_q <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (more_frames) begin
                        frame_q <= frame_q + 1'b1;
                        state_q <= ST_H_SEND;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Counters point at the next beat to load; the two loads never
            // coincide because they belong to different phases.
            if (h_load) begin
                j_q          <= h_idx + 1'b1;
                all_loaded_q <= h_last_d;
            end else if (a_load) begin
                if (a_last_d) begin
                    j_q <= '0;
                    a_q <= a_a_idx + 1'b1;
                end else begin
                    j_q <= a_j_idx + 1'b1;
                    a_q <= a_a_idx;
                end
                all_loaded_q <= a_final;
            end
        end
    end

    axis_src_slot #(.W(I)) u_h_slot (
        .clk      (clk),
        .rst      (rst),
        .load_i   (h_load),
        .data_i   (h_row_d),
        .last_i   (h_last_d),
        .fire_i   (h_fire),
        .bubble_i (bubble),
        .valid_o  (h_valid),
        .data_o   (s_if.H_row),
        .last_o   (h_last),
        .free_o   (h_free)
    );

    axis_src_slot #(.W(DATA_W)) u_a_slot (
        .clk      (clk),
        .rst      (rst),
        .load_i   (a_load),
        .data_i   (alpha_d),
        .last_i   (a_last_d),
        .fire_i   (a_fire),
        .bubble_i (bubble),
        .valid_o  (a_valid),
        .data_o   (s_if.alpha_u_col),
        .last_o   (a_last),
        .free_o   (a_free)
    );

    assign s_if.H_row_tvalid       = h_valid;
    assign s_if.H_row_tlast        = h_last;
    assign s_if.alpha_u_col_tvalid = a_valid;
    assign s_if.alpha_u_col_tlast  = a_last;

    assign busy        = busy_q;
    assign done        = done_q;
    assign frame_idx   = frame_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_h_alpha_stream_driver.sv
// Directed bench for h_alpha_stream_driver with the default J=14, I=7, A=2.
module tb_h_alpha_stream_driver;
    import h_alpha_stream_driver_pkg::*;

    localparam int TJ = 14;
    localparam int TI = 7;
    localparam int TA = 2;
    localparam int TD = 16;
    localparam int TF = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [TF-1:0] frames = '0;
    logic [TD-1:0] alpha_base = '0;
    logic          busy, done;
    logic [TF-1:0] frame_idx;
    state_e        dbg_state;

    h_alpha_stream_driver_if #(.I(TI), .DATA_W(TD)) bus ();

    h_alpha_stream_driver #(.J(TJ), .I(TI), .A(TA), .DATA_W(TD), .FRM_W(TF)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mode        (mode),
        .frames      (frames),
        .alpha_base  (alpha_base),
        .s_if        (bus.master),
        .busy        (busy),
        .done        (done),
        .frame_idx   (frame_idx),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [TI:0]   got_h[$];
    logic [TD:0]   got_a[$];
    int            h_cyc[$];
    int            a_cyc[$];
    logic [TF-1:0] h_fidx[$];
    int done_cnt, done_cyc, stab_err, ovl_err, post_done_valid;
    logic busy_first;

    // Request a run; start is held high across exactly one rising edge.
    task automatic do_start(input logic [1:0] m, input logic [TF-1:0] f, input logic [TD-1:0] b);
        @(negedge clk);
        start = 1'b1;
        mode = m;
        frames = f;
        alpha_base = b;
    endtask

    // Step cycle by cycle after a start: drive ready, record transfers and
    // their cycle numbers (1 = first cycle after the start edge), note hold
    // and overlap violations, and stop a few cycles after done or at max_cyc.
    task automatic run_capture(input bit rnd, input bit poke_done, input int max_cyc);
        bit prev_hs, prev_as;
        logic [TI:0] prev_h;
        logic [TD:0] prev_a;
        int after;
        got_h.delete(); got_a.delete(); h_cyc.delete(); a_cyc.delete(); h_fidx.delete();
        done_cnt = 0; done_cyc = -1; stab_err = 0; ovl_err = 0; post_done_valid = 0;
        prev_hs = 1'b0; prev_as = 1'b0; prev_h = '0; prev_a = '0; after = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            bus.H_row_tready       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.alpha_u_col_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == 1) busy_first = busy;
            if (prev_hs && (!bus.H_row_tvalid || {bus.H_row_tlast, bus.H_row} != prev_h)) stab_err++;
            if (prev_as && (!bus.alpha_u_col_tvalid || {bus.alpha_u_col_tlast, bus.alpha_u_col} != prev_a)) stab_err++;
            if (bus.H_row_tvalid && bus.alpha_u_col_tvalid) ovl_err++;
            if (after >= 0 && (bus.H_row_tvalid || bus.alpha_u_col_tvalid)) post_done_valid++;
            if (bus.H_row_tvalid && bus.H_row_tready) begin
                got_h.push_back({bus.H_row_tlast, bus.H_row});
                h_cyc.push_back(k);
                h_fidx.push_back(frame_idx);
            end
            if (bus.alpha_u_col_tvalid && bus.alpha_u_col_tready) begin
                got_a.push_back({bus.alpha_u_col_tlast, bus.alpha_u_col});
                a_cyc.push_back(k);
            end
            prev_hs = bus.H_row_tvalid && !bus.H_row_tready;
            prev_h  = {bus.H_row_tlast, bus.H_row};
            prev_as = bus.alpha_u_col_tvalid && !bus.alpha_u_col_tready;
            prev_a  = {bus.alpha_u_col_tlast, bus.alpha_u_col};
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
                if (poke_done) start = 1'b1;
                if (after < 0) after = 0;
            end
            if (after >= 0) begin
                after++;
                if (after > 4) break;
            end
        end
    endtask

    // Compare captured H beats with bits (j mod 7), ((j+1) mod 7) and tlast on last_j.
    task automatic check_h(input string tag, input int nbeats, input int last_j);
        logic [TI-1:0] row;
        logic [TI:0] exp;
        n_tests++;
        if (got_h.size() != nbeats) begin
            n_fail++;
            $display("FAIL %s_h_count got=%0d exp=%0d", tag, got_h.size(), nbeats);
        end
        for (int j = 0; j < got_h.size() && j < nbeats; j++) begin
            row = '0;
            row[j % TI] = 1'b1;
            row[(j + 1) % TI] = 1'b1;
            exp = {(j == last_j), row};
            n_tests++;
            if (got_h[j] !== exp) begin
                n_fail++;
                $display("FAIL %s_h_beat%0d got=%b exp=%b", tag, j, got_h[j], exp);
            end
        end
    endtask

    // Compare captured alpha beats with base + i (mod 2^16), tlast every 14th.
    task automatic check_a(input string tag, input int nbeats, input logic [TD-1:0] base);
        logic [TD:0] exp;
        n_tests++;
        if (got_a.size() != nbeats) begin
            n_fail++;
            $display("FAIL %s_a_count got=%0d exp=%0d", tag, got_a.size(), nbeats);
        end
        for (int i = 0; i < got_a.size() && i < nbeats; i++) begin
            exp = {((i % TJ) == TJ - 1), base + TD'(i % (TJ * TA))};
            n_tests++;
            if (got_a[i] !== exp) begin
                n_fail++;
                $display("FAIL %s_a_beat%0d got=%h exp=%h", tag, i, got_a[i], exp);
            end
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_tests++;
        if ({bus.H_row_tvalid, bus.H_row_tlast, bus.alpha_u_col_tvalid, bus.alpha_u_col_tlast,
             busy, done} !== 6'b0 || bus.H_row !== 7'd0 || bus.alpha_u_col !== 16'd0 ||
            frame_idx !== 8'd0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s hv=%b hl=%b h=%b av=%b al=%b a=%h busy=%b done=%b fidx=%0d st=%0d exp all zero/IDLE",
                     tag, bus.H_row_tvalid, bus.H_row_tlast, bus.H_row, bus.alpha_u_col_tvalid,
                     bus.alpha_u_col_tlast, bus.alpha_u_col, busy, done, frame_idx, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.H_row_tready = 1'b1;
        bus.alpha_u_col_tready = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_clean();
        do_start(2'd0, 8'd1, 16'h0100);
        run_capture(1'b0, 1'b0, 200);
        check_h("clean", 14, 13);
        check_int("clean_h_beat0", int'(got_h[0]), int'(8'b0_0000011));
        check_int("clean_h_beat6", int'(got_h[6]), int'(8'b0_1000001));
        check_int("clean_h_beat13", int'(got_h[13]), int'(8'b1_1000001));
        check_a("clean", 28, 16'h0100);
        check_int("clean_a_first", int'(got_a[0]), int'(17'h0_0100));
        check_int("clean_a_last_col0", int'(got_a[13]), int'(17'h1_010D));
        check_int("clean_a_last_col1", int'(got_a[27]), int'(17'h1_011B));
        check_int("clean_busy_after_start", int'(busy_first), 1);
        check_int("clean_first_h_cycle", h_cyc[0], 1);
        check_int("clean_first_a_cycle", a_cyc[0], 15);
        check_int("clean_last_a_cycle", a_cyc[27], 42);
        check_int("clean_done_count", done_cnt, 1);
        check_int("clean_done_cycle", done_cyc, 44);
        check_int("clean_overlap", ovl_err, 0);
    endtask

    task automatic test_backpressure();
        do_start(2'd0, 8'd1, 16'h0100);
        run_capture(1'b1, 1'b0, 2000);
        check_h("bp", 14, 13);
        check_a("bp", 28, 16'h0100);
        check_int("bp_hold_stable", stab_err, 0);
        check_int("bp_overlap", ovl_err, 0);
        check_int("bp_done_count", done_cnt, 1);
    endtask

    task automatic test_bubble();
        do_start(2'd1, 8'd1, 16'h0100);
        run_capture(1'b0, 1'b0, 400);
        check_h("bubble", 14, 13);
        check_a("bubble", 28, 16'h0100);
        for (int i = 1; i < h_cyc.size(); i++) check_int($sformatf("bubble_h_gap%0d", i), h_cyc[i] - h_cyc[i-1], 2);
        for (int i = 1; i < a_cyc.size(); i++) check_int($sformatf("bubble_a_gap%0d", i), a_cyc[i] - a_cyc[i-1], 2);
        check_int("bubble_switch", a_cyc[0], 28);
        check_int("bubble_done_cycle", done_cyc, 84);
        check_int("bubble_done_count", done_cnt, 1);
    endtask

    task automatic test_early_last();
        do_start(2'd2, 8'd1, 16'h0100);
        run_capture(1'b0, 1'b0, 200);
        check_h("early", 13, 12);
        check_int("early_h_beat12", int'(got_h[12]), int'(8'b1_1100000));
        check_a("early", 28, 16'h0100);
        check_int("early_done_cycle", done_cyc, 43);
    endtask

    task automatic test_frames_wrap();
        do_start(2'd0, 8'd3, 16'hFFF0);
        run_capture(1'b0, 1'b0, 500);
        check_int("frames_h_count", got_h.size(), 42);
        check_a("frames", 84, 16'hFFF0);
        check_int("frames_a_beat15", int'(got_a[15]), int'(17'h0_FFFF));
        check_int("frames_a_beat16", int'(got_a[16]), int'(17'h0_0000));
        check_int("frames_f2_a_beat16", int'(got_a[72]), int'(17'h0_0000));
        check_int("frames_idx_f0", int'(h_fidx[0]), 0);
        check_int("frames_idx_f1", int'(h_fidx[14]), 1);
        check_int("frames_idx_f2", int'(h_fidx[28]), 2);
        check_int("frames_done_count", done_cnt, 1);
        check_int("frames_done_cycle", done_cyc, 130);
    endtask

    task automatic test_start_during_done();
        do_start(2'd3, 8'd0, 16'h0100);
        run_capture(1'b0, 1'b1, 200);
        check_h("mode3", 14, 13);
        check_a("mode3", 28, 16'h0100);
        check_int("mode3_done_cycle", done_cyc, 44);
        check_int("start_on_done_no_beats", post_done_valid, 0);
        check_int("start_on_done_busy", int'(busy), 0);
        check_int("start_on_done_state", int'(dbg_state), int'(ST_IDLE));
    endtask

    task automatic test_reset_mid_run();
        do_start(2'd0, 8'd1, 16'h0100);
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check_int("midrun_in_a_send", int'(dbg_state), int'(ST_A_SEND));
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midrun_reset_values");
        rst = 1'b0;
        do_start(2'd0, 8'd1, 16'h0100);
        run_capture(1'b0, 1'b0, 200);
        check_h("after_rst", 14, 13);
        check_a("after_rst", 28, 16'h0100);
        check_int("after_rst_done_cycle", done_cyc, 44);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_backpressure();
        test_bubble();
        test_early_last();
        test_frames_wrap();
        test_start_during_done();
        test_reset_mid_run();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
